// File: rtl/pipe_mem_wb_ctl.sv
// MEM/WB pipeline register: valid/stall/flush control, sub-word load
// alignment with sign/zero extension, registered write-back mux, retire count.
module pipe_mem_wb_ctl #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  parameter  int CNT_W  = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic [ADDR_W-1:0] in_rd_waddr,
  input  logic              in_rd_wena,
  input  logic              in_rd_sel,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [OFF_W-1:0]  in_byte_off,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_dmem_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_rd_waddr,
  output logic              out_rd_wena,
  output logic [DATA_W-1:0] out_rd_wdata,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_dmem_data,
  output logic [CNT_W-1:0]  out_retire_cnt
);

  logic [OFF_W-1:0]  off_h;
  logic [OFF_W-1:0]  off_w;
  logic [DATA_W-1:0] sh_b;
  logic [DATA_W-1:0] sh_h;
  logic [DATA_W-1:0] sh_w;
  logic [DATA_W-1:0] ext_b;
  logic [DATA_W-1:0] ext_h;
  logic [DATA_W-1:0] ext_w;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] wb_data;
  logic              wena_q;
  logic              retire;

  // Half and word accesses are aligned down by masking low offset bits.
  assign off_h = in_byte_off & ~OFF_W'(1);
  assign off_w = in_byte_off & ~OFF_W'(3);

  assign sh_b = in_dmem_data >> {in_byte_off, 3'b000};
  assign sh_h = in_dmem_data >> {off_h, 3'b000};
  assign sh_w = in_dmem_data >> {off_w, 3'b000};

  assign ext_b = {{(DATA_W-8){~in_ld_unsigned & sh_b[7]}}, sh_b[7:0]};
  assign ext_h = {{(DATA_W-16){~in_ld_unsigned & sh_h[15]}}, sh_h[15:0]};

  generate
    if (DATA_W > 32) begin : g_wide
      assign ext_w = {{(DATA_W-32){~in_ld_unsigned & sh_w[31]}}, sh_w[31:0]};
    end else begin : g_narrow
      assign ext_w = in_dmem_data;
    end
  endgenerate

  always_comb begin
    ld_data = in_dmem_data;
    unique case (in_ld_size)
      2'b00:   ld_data = ext_b;
      2'b01:   ld_data = ext_h;
      2'b10:   ld_data = ext_w;
      default: ld_data = in_dmem_data;
    endcase
  end

  assign wb_data = in_rd_sel ? ld_data : in_alu_result;
  assign wena_q  = in_rd_wena & in_valid & (in_rd_waddr != '0);

  // The WB occupant leaves on any non-stalled edge, and a flush also evicts it.
  assign retire = out_valid & (~in_stall | in_flush);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_valid      <= 1'b0;
      out_rd_waddr   <= '0;
      out_rd_wena    <= 1'b0;
      out_rd_wdata   <= '0;
      out_alu_result <= '0;
      out_dmem_data  <= '0;
      out_retire_cnt <= '0;
    end else begin
      if (retire) begin
        out_retire_cnt <= out_retire_cnt + CNT_W'(1);
      end
      if (in_flush) begin
        out_valid    <= 1'b0;
        out_rd_wena  <= 1'b0;
        out_rd_waddr <= '0;
      end else if (!in_stall) begin
        out_valid      <= in_valid;
        out_rd_waddr   <= in_rd_waddr;
        out_rd_wena    <= wena_q;
        out_rd_wdata   <= wb_data;
        out_alu_result <= in_alu_result;
        out_dmem_data  <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_wb_ctl.sv
// Scoreboard bench for pipe_mem_wb_ctl: a 32-bit instance with a 4-bit
// retire counter and a 64-bit instance, both driven by directed vectors.
module tb_pipe_mem_wb_ctl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, a_stall, a_flush, a_wena, a_sel, a_uns;
  logic [4:0]  a_waddr;
  logic [1:0]  a_size, a_off;
  logic [31:0] a_alu, a_dmem;
  logic        a_ovalid, a_owena;
  logic [4:0]  a_owaddr;
  logic [31:0] a_owdata, a_oalu, a_odmem;
  logic [3:0]  a_ocnt;

  logic        b_valid, b_stall, b_flush, b_wena, b_sel, b_uns;
  logic [4:0]  b_waddr;
  logic [1:0]  b_size;
  logic [2:0]  b_off;
  logic [63:0] b_alu, b_dmem;
  logic        b_ovalid, b_owena;
  logic [4:0]  b_owaddr;
  logic [63:0] b_owdata, b_oalu, b_odmem;
  logic [31:0] b_ocnt;

  pipe_mem_wb_ctl #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_a (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(a_valid),
    .in_stall(a_stall), .in_flush(a_flush), .in_rd_waddr(a_waddr),
    .in_rd_wena(a_wena), .in_rd_sel(a_sel), .in_ld_size(a_size),
    .in_ld_unsigned(a_uns), .in_byte_off(a_off),
    .in_alu_result(a_alu), .in_dmem_data(a_dmem),
    .out_valid(a_ovalid), .out_rd_waddr(a_owaddr),
    .out_rd_wena(a_owena), .out_rd_wdata(a_owdata),
    .out_alu_result(a_oalu), .out_dmem_data(a_odmem),
    .out_retire_cnt(a_ocnt)
  );

  pipe_mem_wb_ctl #(.DATA_W(64), .ADDR_W(5), .CNT_W(32)) u_b (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(b_valid),
    .in_stall(b_stall), .in_flush(b_flush), .in_rd_waddr(b_waddr),
    .in_rd_wena(b_wena), .in_rd_sel(b_sel), .in_ld_size(b_size),
    .in_ld_unsigned(b_uns), .in_byte_off(b_off),
    .in_alu_result(b_alu), .in_dmem_data(b_dmem),
    .out_valid(b_ovalid), .out_rd_waddr(b_owaddr),
    .out_rd_wena(b_owena), .out_rd_wdata(b_owdata),
    .out_alu_result(b_oalu), .out_dmem_data(b_odmem),
    .out_retire_cnt(b_ocnt)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic        wena;
    logic [63:0] wdata;
    logic [63:0] alu;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per edge that actually loaded a valid op.
  logic a_took = 1'b0;
  logic b_took = 1'b0;
  always @(posedge clk) begin
    a_took <= rst_n && !a_stall && !a_flush;
    b_took <= rst_n && !b_stall && !b_flush;
  end

  always @(negedge clk) begin
    exp_t e;
    if (a_took && a_ovalid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 64'(a_ovalid), 64'd0);
      end else begin
        e = qa.pop_front();
        chk("a_waddr", 64'(a_owaddr), 64'(e.waddr));
        chk("a_wena", 64'(a_owena), 64'(e.wena));
        chk("a_wdata", 64'(a_owdata), e.wdata);
        chk("a_alu", 64'(a_oalu), e.alu);
      end
    end
    if (b_took && b_ovalid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 64'(b_ovalid), 64'd0);
      end else begin
        e = qb.pop_front();
        chk("b_waddr", 64'(b_owaddr), 64'(e.waddr));
        chk("b_wena", 64'(b_owena), 64'(e.wena));
        chk("b_wdata", b_owdata, e.wdata);
        chk("b_alu", b_oalu, e.alu);
      end
    end
  end

  // Independent retire-count reference for the 32-bit instance.
  logic        mv;
  int unsigned mc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 1'b0;
      mc <= 0;
    end else begin
      if (mv && (!a_stall || a_flush)) mc <= mc + 1;
      if (a_flush) mv <= 1'b0;
      else if (!a_stall) mv <= a_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ia(input logic v, input logic [4:0] wa, input logic we,
                    input logic sel, input logic [1:0] sz, input logic u,
                    input logic [1:0] off, input logic [31:0] alu,
                    input logic [31:0] dm, input logic [31:0] exp_wd,
                    input logic exp_we, input logic push);
    a_valid = v; a_waddr = wa; a_wena = we; a_sel = sel;
    a_size = sz; a_uns = u; a_off = off; a_alu = alu; a_dmem = dm;
    if (v && push) qa.push_back('{wa, exp_we, {32'd0, exp_wd}, {32'd0, alu}});
    step();
  endtask

  task automatic ib(input logic v, input logic [4:0] wa, input logic sel,
                    input logic [1:0] sz, input logic u, input logic [2:0] off,
                    input logic [63:0] alu, input logic [63:0] dm,
                    input logic [63:0] exp_wd);
    b_valid = v; b_waddr = wa; b_wena = 1'b1; b_sel = sel;
    b_size = sz; b_uns = u; b_off = off; b_alu = alu; b_dmem = dm;
    if (v) qb.push_back('{wa, 1'b1, exp_wd, alu});
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_stall = 0; a_flush = 0; a_wena = 0; a_sel = 0;
    a_uns = 0; a_waddr = 0; a_size = 0; a_off = 0; a_alu = 0; a_dmem = 0;
    b_valid = 0; b_stall = 0; b_flush = 0; b_wena = 0; b_sel = 0;
    b_uns = 0; b_waddr = 0; b_size = 0; b_off = 0; b_alu = 0; b_dmem = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 64'(a_ovalid), 64'd0);
    chk("rst_cnt", 64'(a_ocnt), 64'd0);
    chk("rst_wdata", 64'(a_owdata), 64'd0);
    rst_n = 1'b1;

    ia(1, 8, 1, 1, 2'b00, 0, 2, 32'h111, 32'h12F4_5678, 32'hFFFF_FFF4, 1, 1);
    ia(1, 8, 1, 1, 2'b00, 1, 2, 32'h112, 32'h12F4_5678, 32'h0000_00F4, 1, 1);
    ia(1, 9, 1, 1, 2'b01, 0, 3, 32'h222, 32'h8001_7FFF, 32'hFFFF_8001, 1, 1);
    ia(1, 10, 1, 1, 2'b01, 1, 0, 32'h223, 32'h8001_7FFF, 32'h0000_7FFF, 1, 1);
    ia(1, 0, 1, 0, 2'b00, 0, 0, 32'h77, 32'h0, 32'h77, 0, 1);
    ia(1, 11, 1, 1, 2'b10, 0, 1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1);
    ia(1, 12, 0, 0, 2'b11, 0, 0, 32'hABC, 32'h0, 32'hABC, 0, 1);
    ia(0, 13, 1, 0, 2'b00, 0, 0, 32'h5, 32'h0, 32'h5, 1, 1);
    chk("bubble_valid", 64'(a_ovalid), 64'd0);
    chk("bubble_wena", 64'(a_owena), 64'd0);
    chk("cnt_stream", 64'(a_ocnt), 64'd7);

    ia(1, 3, 1, 0, 2'b00, 0, 0, 32'h55, 32'h0, 32'h55, 1, 1);
    chk("cnt_pre_stall", 64'(a_ocnt), 64'd7);
    a_stall = 1; a_valid = 1; a_waddr = 9; a_alu = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu", 64'(a_oalu), 64'h55);
      chk("stall_waddr", 64'(a_owaddr), 64'd3);
      chk("stall_valid", 64'(a_ovalid), 64'd1);
      chk("stall_cnt", 64'(a_ocnt), 64'd7);
    end
    a_flush = 1;
    step();
    chk("flush_valid", 64'(a_ovalid), 64'd0);
    chk("flush_wena", 64'(a_owena), 64'd0);
    chk("flush_waddr", 64'(a_owaddr), 64'd0);
    chk("flush_cnt", 64'(a_ocnt), 64'd8);
    a_flush = 0; a_stall = 0; a_valid = 0;
    step();
    chk("post_flush_cnt", 64'(a_ocnt), 64'd8);
    chk("model_cnt", 64'(a_ocnt), 64'(mc[3:0]));

    ia(1, 5, 1, 0, 2'b00, 0, 0, 32'h66, 32'h0, 32'h66, 1, 0);
    chk("pre_rst_valid", 64'(a_ovalid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(a_ovalid), 64'd0);
    chk("async_rst_waddr", 64'(a_owaddr), 64'd0);
    chk("async_rst_alu", 64'(a_oalu), 64'd0);
    chk("async_rst_cnt", 64'(a_ocnt), 64'd0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      ia(1, 5'(i % 31 + 1), 1, 0, 2'b00, 0, 0, 32'(i), 32'h0,
         32'(i), 1, 1);
    end
    ia(0, 1, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
    chk("cnt_wrap", 64'(a_ocnt), 64'd1);
    chk("model_cnt_wrap", 64'(a_ocnt), 64'(mc[3:0]));

    ib(1, 4, 1, 2'b10, 0, 4, 64'h1, 64'h8000_0000_0000_0001,
       64'hFFFF_FFFF_8000_0000);
    ib(1, 5, 1, 2'b11, 0, 4, 64'h2, 64'h8000_0000_0000_0001,
       64'h8000_0000_0000_0001);
    ib(1, 6, 1, 2'b00, 1, 7, 64'h3, 64'h8000_0000_0000_0001,
       64'h0000_0000_0000_0080);
    ib(1, 7, 1, 2'b01, 0, 7, 64'h4, 64'h8000_0000_0000_0001,
       64'hFFFF_FFFF_FFFF_8000);
    ib(1, 8, 1, 2'b10, 1, 1, 64'h5, 64'h1234_5678_9ABC_DEF0,
       64'h0000_0000_9ABC_DEF0);
    ib(1, 9, 1, 2'b10, 0, 3, 64'h6, 64'h1234_5678_9ABC_DEF0,
       64'hFFFF_FFFF_9ABC_DEF0);
    ib(1, 10, 0, 2'b00, 0, 0, 64'hCAFE, 64'h0, 64'hCAFE);
    ib(0, 0, 0, 2'b00, 0, 0, 64'h0, 64'h0, 64'h0);
    chk("b_cnt", 64'(b_ocnt), 64'd7);
    step();

    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
